// File: rtl/multimode_ring_counter.sv
// Ring / Johnson shift counter with bidirectional stepping, parallel load,
// sequence position tracking, and illegal-state detection with self-correction.
module multimode_ring_counter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count_out,
  output logic [IDXW-1:0]  step_idx,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [IDXW-1:0]  step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] count_inc, count_inv, count_inv_inc, count_dec;
  logic             ring_ok, johnson_ok;
  logic [IDXW-1:0]  last_idx;

  function automatic logic [WIDTH-1:0] start_state(input logic m);
    return m ? '0 : WIDTH'(1);
  endfunction

  // Johnson legality: a run of ones anchored at bit 0 is 0..01..1 (x & (x+1) == 0);
  // a run anchored at the MSB is the complement of that form.
  always_comb begin
    count_inc     = count_q + WIDTH'(1);
    count_dec     = count_q - WIDTH'(1);
    count_inv     = ~count_q;
    count_inv_inc = count_inv + WIDTH'(1);
    ring_ok       = (count_q != '0) && ((count_q & count_dec) == '0);
    johnson_ok    = ((count_q & count_inc) == '0) || ((count_inv & count_inv_inc) == '0);
    illegal       = mode_q ? !johnson_ok : !ring_ok;
  end

  assign last_idx = mode_q ? IDXW'(2*WIDTH-1) : IDXW'(WIDTH-1);

  always_comb begin
    count_d = count_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    mode_d  = mode_q;
    if (load) begin
      count_d = load_data;
      step_d  = '0;
    end else if (mode != mode_q) begin
      mode_d  = mode;
      count_d = start_state(mode);
      step_d  = '0;
    end else if (en && illegal) begin
      count_d = start_state(mode_q);
      step_d  = '0;
    end else if (en) begin
      if (!dir) begin
        count_d = {count_q[WIDTH-2:0], mode_q ? ~count_q[WIDTH-1] : count_q[WIDTH-1]};
        if (step_q == last_idx) begin
          step_d = '0;
          wrap_d = 1'b1;
        end else begin
          step_d = step_q + IDXW'(1);
        end
      end else begin
        count_d = {mode_q ? ~count_q[0] : count_q[0], count_q[WIDTH-1:1]};
        if (step_q == '0) begin
          step_d = last_idx;
          wrap_d = 1'b1;
        end else begin
          step_d = step_q - IDXW'(1);
        end
      end
    end
  end

  // Reset adopts the mode input directly so the counter comes up in the requested sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= mode;
      count_q <= start_state(mode);
      step_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out = count_q;
  assign step_idx  = step_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Directed scoreboard bench for multimode_ring_counter (WIDTH=8): expectations are
// queued as each step is driven and compared one cycle later, just after the edge.
module tb_multimode_ring_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] count_out;
  logic [3:0] step_idx;
  logic       wrap;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic [3:0] idx;
    logic       wr;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  logic [7:0] ring_seq [0:8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] john_seq [0:16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

  multimode_ring_counter #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .dir       (dir),
    .load      (load),
    .load_data (load_data),
    .count_out (count_out),
    .step_idx  (step_idx),
    .wrap      (wrap),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [7:0] ld,
                       input logic e, input logic m, input logic d);
    @(negedge clk);
    reset = r; load = l; load_data = ld; en = e; mode = m; dir = d;
  endtask

  // Queue the expected post-edge state, clock once, then pop and compare.
  task automatic step(input string tag, input logic [7:0] c, input logic [3:0] i,
                      input logic w, input logic il);
    exp_t e;
    e.tag = tag; e.cnt = c; e.idx = i; e.wr = w; e.ill = il;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".count"},   {24'h0, count_out}, {24'h0, e.cnt});
      chk({e.tag, ".idx"},     {28'h0, step_idx},  {28'h0, e.idx});
      chk({e.tag, ".wrap"},    {31'h0, wrap},      {31'h0, e.wr});
      chk({e.tag, ".illegal"}, {31'h0, illegal},   {31'h0, e.ill});
    end
  endtask

  initial begin
    // Ring reset and full left rotation
    drive(1, 0, 8'h00, 0, 0, 0); step("rst_ring", 8'h01, 4'd0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 8'h00, 1, 0, 0);
      step($sformatf("ring_l%0d", i), ring_seq[i], 4'(i % 8), i == 8, 0);
    end
    drive(0, 0, 8'h00, 0, 0, 0); step("ring_hold", 8'h01, 4'd0, 0, 0);

    // Right step from 01 wraps backwards
    drive(0, 0, 8'h00, 1, 0, 1); step("ring_r_wrap", 8'h80, 4'd7, 1, 0);
    drive(0, 0, 8'h00, 0, 0, 1); step("ring_hold2", 8'h80, 4'd7, 0, 0);

    // Illegal load held, then corrected on the next enabled step
    drive(0, 1, 8'h05, 1, 0, 1); step("load_bad", 8'h05, 4'd0, 0, 1);
    drive(0, 0, 8'h00, 0, 0, 1); step("bad_held", 8'h05, 4'd0, 0, 1);
    drive(0, 0, 8'h00, 1, 0, 1); step("ring_fix", 8'h01, 4'd0, 0, 0);

    // Mode change to Johnson without enable
    drive(0, 1, 8'h08, 0, 0, 0); step("load_08", 8'h08, 4'd0, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 0); step("mode_to_j", 8'h00, 4'd0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0); step("j_resume1", 8'h01, 4'd1, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0); step("j_resume2", 8'h03, 4'd2, 0, 0);

    // Johnson reset and full left period
    drive(1, 0, 8'h00, 0, 1, 0); step("rst_john", 8'h00, 4'd0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 8'h00, 1, 1, 0);
      step($sformatf("john_l%0d", i), john_seq[i], 4'(i % 16), i == 16, 0);
    end
    drive(0, 0, 8'h00, 1, 1, 1); step("john_r_wrap", 8'h80, 4'd15, 1, 0);

    // Johnson illegal correction and legal MSB-anchored load
    drive(0, 1, 8'h05, 0, 1, 0); step("j_load_bad", 8'h05, 4'd0, 0, 1);
    drive(0, 0, 8'h00, 1, 1, 0); step("j_fix", 8'h00, 4'd0, 0, 0);
    drive(0, 1, 8'hF0, 0, 1, 0); step("j_load_f0", 8'hF0, 4'd0, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 0); step("j_step_f0", 8'hE0, 4'd1, 0, 0);

    // Reset beats simultaneous load, enable and mode change
    drive(1, 1, 8'hAA, 1, 0, 0); step("rst_prio", 8'h01, 4'd0, 0, 0);

    // All-zeros is illegal in ring mode
    drive(0, 1, 8'h00, 0, 0, 0); step("ring_zero", 8'h00, 4'd0, 0, 1);
    drive(0, 0, 8'h00, 1, 0, 0); step("ring_zero_fix", 8'h01, 4'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
